// File: rtl/simple_ppu_mem_word_port.sv
// Word-memory responder: splits each 32-bit read/write into two 16-bit req/ack backend
// transactions (low half at the even address first); busy blocks the initiator, extra requests set overrun.
module simple_ppu_mem_word_port #(
   parameter int HW_ADDR_W = 25
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_word_rd,
   input  logic                 mem_word_wr,
   input  logic [23:0]          mem_word_addr,
   input  logic [31:0]          mem_word_data,
   output logic [31:0]          mem_word_q,
   output logic                 mem_word_rdvalid,
   output logic                 mem_word_busy,
   output logic                 mem_word_overrun,
   output logic                 ram_req,
   output logic                 ram_we,
   output logic [HW_ADDR_W-1:0] ram_addr,
   output logic [15:0]          ram_wdata,
   input  logic [15:0]          ram_rdata,
   input  logic                 ram_ack
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI
   } state_t;

   state_t                 state_q, state_d;
   logic [23:0]            addr_q, addr_d;
   logic [15:0]            data_hi_q, data_hi_d;
   logic                   is_wr_q, is_wr_d;
   logic [15:0]            lo_q, lo_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   rdvalid_q, rdvalid_d;
   logic                   overrun_q, overrun_d;
   logic                   ram_req_q, ram_req_d;
   logic                   ram_we_q, ram_we_d;
   logic [HW_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [15:0]            ram_wdata_q, ram_wdata_d;
   logic                   req_any;

   assign req_any = mem_word_rd | mem_word_wr;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_hi_d   = data_hi_q;
      is_wr_d     = is_wr_q;
      lo_d        = lo_q;
      rdata_d     = rdata_q;
      rdvalid_d   = 1'b0;
      overrun_d   = overrun_q;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               // Write wins a simultaneous rd+wr; the lost read is reported as an overrun.
               addr_d      = mem_word_addr;
               data_hi_d   = mem_word_data[31:16];
               is_wr_d     = mem_word_wr;
               ram_req_d   = 1'b1;
               ram_we_d    = mem_word_wr;
               ram_addr_d  = HW_ADDR_W'({mem_word_addr, 1'b0});
               ram_wdata_d = mem_word_data[15:0];
               state_d     = ST_LO;
               if (mem_word_rd && mem_word_wr) begin
                  overrun_d = 1'b1;
               end
            end
         end
         ST_LO: begin
            if (req_any) begin
               overrun_d = 1'b1;
            end
            if (ram_ack) begin
               if (!is_wr_q) begin
                  lo_d = ram_rdata;
               end
               ram_addr_d  = HW_ADDR_W'({addr_q, 1'b1});
               ram_wdata_d = data_hi_q;
               state_d     = ST_HI;
            end
         end
         ST_HI: begin
            if (req_any) begin
               overrun_d = 1'b1;
            end
            if (ram_ack) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               state_d   = ST_IDLE;
               if (!is_wr_q) begin
                  rdata_d   = {ram_rdata, lo_q};
                  rdvalid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         data_hi_q   <= '0;
         is_wr_q     <= 1'b0;
         lo_q        <= '0;
         rdata_q     <= '0;
         rdvalid_q   <= 1'b0;
         overrun_q   <= 1'b0;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_hi_q   <= data_hi_d;
         is_wr_q     <= is_wr_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         rdvalid_q   <= rdvalid_d;
         overrun_q   <= overrun_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign mem_word_q       = rdata_q;
   assign mem_word_rdvalid = rdvalid_q;
   assign mem_word_busy    = req_any | (state_q != ST_IDLE);
   assign mem_word_overrun = overrun_q;
   assign ram_req          = ram_req_q;
   assign ram_we           = ram_we_q;
   assign ram_addr         = ram_addr_q;
   assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_simple_ppu_mem_word_port.sv
// Bench for simple_ppu_mem_word_port: directed scenarios plus randomized word traffic
// against a word-level memory model and a half-word backend responder with configurable wait.
module tb_simple_ppu_mem_word_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_word_rd = 1'b0;
   logic        mem_word_wr = 1'b0;
   logic [23:0] mem_word_addr = '0;
   logic [31:0] mem_word_data = '0;
   logic [31:0] mem_word_q;
   logic        mem_word_rdvalid;
   logic        mem_word_busy;
   logic        mem_word_overrun;
   logic        ram_req;
   logic        ram_we;
   logic [24:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        ram_ack;

   simple_ppu_mem_word_port #(.HW_ADDR_W(25)) dut (
      .clk(clk), .reset(reset),
      .mem_word_rd(mem_word_rd), .mem_word_wr(mem_word_wr),
      .mem_word_addr(mem_word_addr), .mem_word_data(mem_word_data),
      .mem_word_q(mem_word_q), .mem_word_rdvalid(mem_word_rdvalid),
      .mem_word_busy(mem_word_busy), .mem_word_overrun(mem_word_overrun),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [24:0] a;
      logic        we;
      logic [15:0] d;
   } txn_t;

   int          pass_cnt = 0;
   int          chk_cnt = 0;
   txn_t        log_q[$];
   logic [15:0] hmem[int];
   logic [31:0] wmem[int];
   logic [31:0] exp_q = '0;
   int          bk_wait = 0;
   logic        bk_manual = 1'b0;
   logic        bk_man_ack = 1'b0;
   logic [15:0] bk_man_data = '0;

   logic        stim_rd[32];
   logic        stim_wr[32];
   logic [23:0] stim_addr[32];
   logic [31:0] stim_data[32];
   logic        obs_req[32];
   logic        obs_we[32];
   logic        obs_busy[32];
   logic        obs_rdv[32];
   logic        obs_ovr[32];
   logic [31:0] obs_q[32];

   function automatic logic [15:0] dflt(input logic [24:0] h);
      return h[15:0] ^ 16'hC3A5;
   endfunction

   // Backend: acks after bk_wait idle cycles of each presented transaction.
   initial begin
      int cnt;
      cnt = 0;
      ram_ack = 1'b0;
      ram_rdata = '0;
      forever begin
         @(negedge clk);
         if (bk_manual) begin
            ram_ack = bk_man_ack;
            ram_rdata = bk_man_data;
            cnt = 0;
         end else if (ram_req === 1'b1) begin
            if (cnt >= bk_wait) begin
               ram_ack = 1'b1;
               log_q.push_back({ram_addr, ram_we, ram_wdata});
               if (ram_we) begin
                  hmem[int'(ram_addr)] = ram_wdata;
                  ram_rdata = 16'($urandom);
               end else begin
                  ram_rdata = hmem.exists(int'(ram_addr)) ? hmem[int'(ram_addr)] : dflt(ram_addr);
               end
               cnt = 0;
            end else begin
               ram_ack = 1'b0;
               ram_rdata = 16'($urandom);
               cnt++;
            end
         end else begin
            ram_ack = 1'b0;
            ram_rdata = 16'($urandom);
            cnt = 0;
         end
      end
   end

   task automatic clear_stim();
      for (int i = 0; i < 32; i++) begin
         stim_rd[i] = 1'b0;
         stim_wr[i] = 1'b0;
         stim_addr[i] = '0;
         stim_data[i] = '0;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         mem_word_rd = stim_rd[i];
         mem_word_wr = stim_wr[i];
         mem_word_addr = stim_addr[i];
         mem_word_data = stim_data[i];
         @(negedge clk);
         obs_req[i] = ram_req;
         obs_we[i] = ram_we;
         obs_busy[i] = mem_word_busy;
         obs_rdv[i] = mem_word_rdvalid;
         obs_ovr[i] = mem_word_overrun;
         obs_q[i] = mem_word_q;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      mem_word_rd = 1'b0;
      mem_word_wr = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++; if (ram_req !== 1'b0) $display("FAIL reset_req got %b want 0", ram_req); else pass_cnt++;
      chk_cnt++; if (ram_we !== 1'b0) $display("FAIL reset_we got %b want 0", ram_we); else pass_cnt++;
      chk_cnt++; if (ram_addr !== 25'h0) $display("FAIL reset_addr got %h want 0", ram_addr); else pass_cnt++;
      chk_cnt++; if (ram_wdata !== 16'h0) $display("FAIL reset_wdata got %h want 0", ram_wdata); else pass_cnt++;
      chk_cnt++; if (mem_word_q !== 32'h0) $display("FAIL reset_q got %h want 0", mem_word_q); else pass_cnt++;
      chk_cnt++; if (mem_word_rdvalid !== 1'b0) $display("FAIL reset_rdvalid got %b want 0", mem_word_rdvalid); else pass_cnt++;
      chk_cnt++; if (mem_word_overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", mem_word_overrun); else pass_cnt++;
      chk_cnt++; if (mem_word_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", mem_word_busy); else pass_cnt++;
      mem_word_rd = 1'b1;
      #1;
      chk_cnt++; if (mem_word_busy !== 1'b1) $display("FAIL reset_busy_comb got %b want 1", mem_word_busy); else pass_cnt++;
      mem_word_rd = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q = '0;
   endtask

   task automatic test_write_zero_wait();
      txn_t e0, e1;
      e0 = {25'h080000, 1'b1, 16'h5555};
      e1 = {25'h080001, 1'b1, 16'hAAAA};
      log_q.delete();
      bk_wait = 0;
      clear_stim();
      stim_wr[0] = 1'b1; stim_addr[0] = 24'h040000; stim_data[0] = 32'hAAAA5555;
      run_cycles(6);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL wr0_count got %0d want 2", log_q.size()); else pass_cnt++;
      if (log_q.size() == 2) begin
         chk_cnt++; if (log_q[0] !== e0) $display("FAIL wr0_lo got %h want %h", log_q[0], e0); else pass_cnt++;
         chk_cnt++; if (log_q[1] !== e1) $display("FAIL wr0_hi got %h want %h", log_q[1], e1); else pass_cnt++;
      end
      for (int i = 0; i < 6; i++) begin
         chk_cnt++; if (obs_req[i] !== (i >= 1 && i <= 2)) $display("FAIL wr0_req c%0d got %b", i, obs_req[i]); else pass_cnt++;
         chk_cnt++; if (obs_busy[i] !== (i <= 2)) $display("FAIL wr0_busy c%0d got %b", i, obs_busy[i]); else pass_cnt++;
         chk_cnt++; if (obs_rdv[i] !== 1'b0) $display("FAIL wr0_rdvalid c%0d got %b want 0", i, obs_rdv[i]); else pass_cnt++;
      end
      chk_cnt++; if (obs_we[1] !== 1'b1 || obs_we[3] !== 1'b0) $display("FAIL wr0_we got %b/%b want 1/0", obs_we[1], obs_we[3]); else pass_cnt++;
      chk_cnt++; if (obs_q[5] !== exp_q) $display("FAIL wr0_q got %h want %h", obs_q[5], exp_q); else pass_cnt++;
   endtask

   task automatic test_read_delayed();
      hmem[int'(25'h080002)] = 16'h1234;
      hmem[int'(25'h080003)] = 16'hBEEF;
      log_q.delete();
      bk_wait = 2;
      clear_stim();
      stim_rd[0] = 1'b1; stim_addr[0] = 24'h040001; stim_data[0] = 32'h0;
      run_cycles(9);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL rd_count got %0d want 2", log_q.size()); else pass_cnt++;
      if (log_q.size() == 2) begin
         chk_cnt++; if (log_q[0].a !== 25'h080002 || log_q[0].we !== 1'b0) $display("FAIL rd_lo got %h/%b want 080002/0", log_q[0].a, log_q[0].we); else pass_cnt++;
         chk_cnt++; if (log_q[1].a !== 25'h080003 || log_q[1].we !== 1'b0) $display("FAIL rd_hi got %h/%b want 080003/0", log_q[1].a, log_q[1].we); else pass_cnt++;
      end
      for (int i = 0; i < 9; i++) begin
         chk_cnt++; if (obs_rdv[i] !== (i == 7)) $display("FAIL rd_rdvalid c%0d got %b", i, obs_rdv[i]); else pass_cnt++;
         chk_cnt++; if (obs_busy[i] !== (i <= 6)) $display("FAIL rd_busy c%0d got %b", i, obs_busy[i]); else pass_cnt++;
         chk_cnt++; if (obs_q[i] !== ((i >= 7) ? 32'hBEEF1234 : exp_q)) $display("FAIL rd_q c%0d got %h", i, obs_q[i]); else pass_cnt++;
      end
      exp_q = 32'hBEEF1234;
   endtask

   task automatic test_read_then_write();
      log_q.delete();
      bk_wait = 1;
      clear_stim();
      stim_wr[0] = 1'b1; stim_addr[0] = 24'h000010; stim_data[0] = $urandom;
      run_cycles(7);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL rw_count got %0d want 2", log_q.size()); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         chk_cnt++; if (obs_q[i] !== 32'hBEEF1234) $display("FAIL rw_q c%0d got %h want beef1234", i, obs_q[i]); else pass_cnt++;
         chk_cnt++; if (obs_rdv[i] !== 1'b0) $display("FAIL rw_rdvalid c%0d got %b want 0", i, obs_rdv[i]); else pass_cnt++;
      end
   endtask

   task automatic test_rd_wr_collision();
      logic [31:0] d;
      d = $urandom;
      log_q.delete();
      bk_wait = 0;
      clear_stim();
      stim_rd[0] = 1'b1; stim_wr[0] = 1'b1; stim_addr[0] = 24'h000020; stim_data[0] = d;
      run_cycles(6);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL coll_count got %0d want 2", log_q.size()); else pass_cnt++;
      if (log_q.size() == 2) begin
         chk_cnt++; if (log_q[0] !== {25'h000040, 1'b1, d[15:0]}) $display("FAIL coll_lo got %h", log_q[0]); else pass_cnt++;
         chk_cnt++; if (log_q[1] !== {25'h000041, 1'b1, d[31:16]}) $display("FAIL coll_hi got %h", log_q[1]); else pass_cnt++;
      end
      chk_cnt++; if (obs_ovr[0] !== 1'b0) $display("FAIL coll_ovr_pre got %b want 0", obs_ovr[0]); else pass_cnt++;
      chk_cnt++; if (obs_ovr[5] !== 1'b1) $display("FAIL coll_ovr got %b want 1", obs_ovr[5]); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++; if (obs_rdv[i] !== 1'b0) $display("FAIL coll_rdvalid c%0d got %b want 0", i, obs_rdv[i]); else pass_cnt++;
      end
   endtask

   task automatic test_overrun_in_hi();
      logic [31:0] d;
      do_reset();
      d = $urandom;
      log_q.delete();
      bk_wait = 1;
      clear_stim();
      stim_wr[0] = 1'b1; stim_addr[0] = 24'h000022; stim_data[0] = d;
      stim_wr[3] = 1'b1; stim_addr[3] = 24'h000099; stim_data[3] = ~d;
      run_cycles(7);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL ovr_count got %0d want 2", log_q.size()); else pass_cnt++;
      if (log_q.size() == 2) begin
         chk_cnt++; if (log_q[0] !== {25'h000044, 1'b1, d[15:0]}) $display("FAIL ovr_lo got %h", log_q[0]); else pass_cnt++;
         chk_cnt++; if (log_q[1] !== {25'h000045, 1'b1, d[31:16]}) $display("FAIL ovr_hi got %h", log_q[1]); else pass_cnt++;
      end
      chk_cnt++; if (obs_ovr[3] !== 1'b0) $display("FAIL ovr_pre got %b want 0", obs_ovr[3]); else pass_cnt++;
      chk_cnt++; if (obs_ovr[4] !== 1'b1) $display("FAIL ovr_set got %b want 1", obs_ovr[4]); else pass_cnt++;
      chk_cnt++; if (obs_busy[5] !== 1'b0) $display("FAIL ovr_done_busy got %b want 0", obs_busy[5]); else pass_cnt++;
      clear_stim();
      run_cycles(5);
      chk_cnt++; if (obs_ovr[4] !== 1'b1) $display("FAIL ovr_sticky got %b want 1", obs_ovr[4]); else pass_cnt++;
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      do_reset();
      log_q.delete();
      bk_wait = 2;
      clear_stim();
      stim_rd[0] = 1'b1; stim_addr[0] = 24'h000030;
      run_cycles(5);
      chk_cnt++; if (log_q.size() != 1) $display("FAIL rst_mid_lo got %0d txns want 1", log_q.size()); else pass_cnt++;
      @(posedge clk);
      #2;
      reset = 1'b1;
      exp_q = '0;
      #1;
      chk_cnt++; if (ram_req !== 1'b0) $display("FAIL rst_mid_req got %b want 0", ram_req); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (mem_word_q !== 32'h0 || mem_word_rdvalid !== 1'b0 || mem_word_overrun !== 1'b0)
         $display("FAIL rst_mid_out got q=%h v=%b o=%b want 0", mem_word_q, mem_word_rdvalid, mem_word_overrun); else pass_cnt++;
      chk_cnt++; if (ram_addr !== 25'h0 || ram_wdata !== 16'h0 || ram_we !== 1'b0 || mem_word_busy !== 1'b0)
         $display("FAIL rst_mid_ram got a=%h d=%h we=%b b=%b want 0", ram_addr, ram_wdata, ram_we, mem_word_busy); else pass_cnt++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_stim();
      run_cycles(4);
      for (int i = 0; i < 4; i++) begin
         chk_cnt++; if (obs_rdv[i] !== 1'b0 || obs_req[i] !== 1'b0) $display("FAIL rst_mid_idle c%0d got v=%b r=%b want 0", i, obs_rdv[i], obs_req[i]); else pass_cnt++;
      end
      d = 32'h0F0F_A5C3;
      log_q.delete();
      bk_wait = 0;
      clear_stim();
      stim_wr[0] = 1'b1; stim_addr[0] = 24'h000031; stim_data[0] = d;
      run_cycles(6);
      chk_cnt++; if (log_q.size() != 2) $display("FAIL rst_wr_count got %0d want 2", log_q.size()); else pass_cnt++;
      if (log_q.size() == 2) begin
         chk_cnt++; if (log_q[0] !== {25'h000062, 1'b1, 16'hA5C3}) $display("FAIL rst_wr_lo got %h", log_q[0]); else pass_cnt++;
         chk_cnt++; if (log_q[1] !== {25'h000063, 1'b1, 16'h0F0F}) $display("FAIL rst_wr_hi got %h", log_q[1]); else pass_cnt++;
      end
      chk_cnt++; if (obs_req[1] !== 1'b1 || obs_req[2] !== 1'b1 || obs_req[3] !== 1'b0)
         $display("FAIL rst_wr_req got %b%b%b want 110", obs_req[1], obs_req[2], obs_req[3]); else pass_cnt++;
   endtask

   task automatic test_stray_ack();
      bk_man_data = 16'($urandom);
      bk_man_ack = 1'b1;
      bk_manual = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++; if (ram_req !== 1'b0 || mem_word_rdvalid !== 1'b0 || mem_word_busy !== 1'b0)
            $display("FAIL stray_ctl c%0d got r=%b v=%b b=%b want 0", i, ram_req, mem_word_rdvalid, mem_word_busy); else pass_cnt++;
         chk_cnt++; if (ram_addr !== 25'h000063 || ram_wdata !== 16'h0F0F)
            $display("FAIL stray_ram c%0d got a=%h d=%h want 000063/0f0f", i, ram_addr, ram_wdata); else pass_cnt++;
         chk_cnt++; if (mem_word_q !== exp_q) $display("FAIL stray_q c%0d got %h want %h", i, mem_word_q, exp_q); else pass_cnt++;
      end
      bk_manual = 1'b0;
      bk_man_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int k = 0; k < 24; k++) begin
         logic [23:0] a;
         logic [31:0] d, want;
         logic        isw;
         int          w, n, nrdv;
         a = 24'h000100 + 24'($urandom_range(0, 7));
         d = $urandom;
         isw = 1'($urandom_range(0, 1));
         w = $urandom_range(0, 3);
         n = 5 + 2 * w;
         want = wmem.exists(int'(a)) ? wmem[int'(a)] : {dflt({a, 1'b1}), dflt({a, 1'b0})};
         log_q.delete();
         bk_wait = w;
         clear_stim();
         stim_rd[0] = ~isw; stim_wr[0] = isw; stim_addr[0] = a; stim_data[0] = d;
         run_cycles(n);
         chk_cnt++; if (log_q.size() != 2) $display("FAIL rnd%0d_count got %0d want 2", k, log_q.size()); else pass_cnt++;
         if (log_q.size() == 2) begin
            chk_cnt++; if (log_q[0] !== {a, 1'b0, isw, d[15:0]}) $display("FAIL rnd%0d_lo got %h want %h", k, log_q[0], {a, 1'b0, isw, d[15:0]}); else pass_cnt++;
            chk_cnt++; if (log_q[1] !== {a, 1'b1, isw, d[31:16]}) $display("FAIL rnd%0d_hi got %h want %h", k, log_q[1], {a, 1'b1, isw, d[31:16]}); else pass_cnt++;
         end
         nrdv = 0;
         for (int i = 0; i < n; i++) nrdv += int'(obs_rdv[i]);
         chk_cnt++; if (nrdv != (isw ? 0 : 1)) $display("FAIL rnd%0d_rdvcount got %0d want %0d", k, nrdv, isw ? 0 : 1); else pass_cnt++;
         chk_cnt++; if (obs_rdv[3 + 2 * w] !== ~isw) $display("FAIL rnd%0d_rdvtime got %b want %b", k, obs_rdv[3 + 2 * w], ~isw); else pass_cnt++;
         chk_cnt++; if (obs_busy[2 + 2 * w] !== 1'b1 || obs_busy[3 + 2 * w] !== 1'b0)
            $display("FAIL rnd%0d_busy got %b%b want 10", k, obs_busy[2 + 2 * w], obs_busy[3 + 2 * w]); else pass_cnt++;
         if (isw) wmem[int'(a)] = d;
         else exp_q = want;
         chk_cnt++; if (obs_q[n - 1] !== exp_q) $display("FAIL rnd%0d_q got %h want %h", k, obs_q[n - 1], exp_q); else pass_cnt++;
      end
      chk_cnt++; if (mem_word_overrun !== 1'b0) $display("FAIL rnd_overrun got %b want 0", mem_word_overrun); else pass_cnt++;
   endtask

   initial begin
      clear_stim();
      test_reset();
      test_write_zero_wait();
      test_read_delayed();
      test_read_then_write();
      test_rd_wr_collision();
      test_overrun_in_hi();
      test_reset_mid_read();
      test_stray_ack();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/simple_ppu_mem_word_port.md
# simple_ppu_mem_word_port

Responder for the PPU word-memory port: it accepts single-cycle 32-bit word read and write requests from the drawing engine and services each one as two sequential 16-bit transactions on a req/ack half-word memory backend (SDRAM/BRAM adapter). It returns read data with a completion strobe and holds `mem_word_busy` while a word is in flight. It sits between `simple_ppu_ppu` and the framebuffer memory controller.

## Interface
- `HW_ADDR_W`, default 25: half-word address width on the backend; must equal 24 + 1.
- `clk`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_word_rd`  in  1  single-cycle word read request.
- `mem_word_wr`  in  1  single-cycle word write request.
- `mem_word_addr`  in  24  word address, sampled with the request.
- `mem_word_data`  in  32  write data, sampled with the request.
- `mem_word_q`  out  32  last completed read word; held until the next read completes.
- `mem_word_rdvalid`  out  1  one-cycle pulse: `mem_word_q` updated this cycle.
- `mem_word_busy`  out  1  request in flight or being presented; initiator must not issue.
- `mem_word_overrun`  out  1  sticky: a request was dropped; cleared only by reset.
- `ram_req`  out  1  backend request, level, registered.
- `ram_we`  out  1  backend write enable, registered, valid with `ram_req`.
- `ram_addr`  out  HW_ADDR_W  half-word address, registered.
- `ram_wdata`  out  16  half-word write data, registered.
- `ram_rdata`  in  16  half-word read data, valid when `ram_ack` is high.
- `ram_ack`  in  1  one-cycle completion pulse for the current backend transaction.

## Operation
- States: ST_IDLE, ST_LO, ST_HI.
- ST_IDLE: if `mem_word_wr` or `mem_word_rd` is high, latch the address, the data and the type, and go to ST_LO. `wr` has priority over `rd`. If both are high, perform the write, drop the read, and set `mem_word_overrun`.
- Entering ST_LO: `ram_req`=1, `ram_we`=type, `ram_addr`={addr,1'b0}, `ram_wdata`=data[15:0].
- ST_LO, on `ram_ack`:
  - For a read, capture `ram_rdata` into the low holding register.
  - Load `ram_addr`={addr,1'b1` and `ram_wdata`=data[31:16] with `ram_req` kept high, then go to ST_HI.
- ST_HI, on `ram_ack`:
  - Drop `ram_req` and `ram_we`, then go to ST_IDLE.
  - For a read, `mem_word_q` <= {ram_rdata, low holding register} and pulse `mem_word_rdvalid`.
  - A write produces no rdvalid pulse.
- Backend contract: each `ram_ack` completes exactly the transaction currently presented. If `ram_req` is still high at the next edge, that is a new transaction (the HI half). `ram_ack` while `ram_req`=0 is ignored.
- `mem_word_busy` = `mem_word_rd` | `mem_word_wr` | (state != ST_IDLE). This is combinational from the request inputs, so an initiator that registered a request sees busy in the following cycle's sampling.
- Any request arriving while state != ST_IDLE is dropped and sets `mem_word_overrun`. The in-flight transaction is unaffected.
- Half-word order is fixed: low half at the even address first, then high half at the odd address. This matches pixel packing, where the pixel at the even index is in bits [15:0].

## Timing
- Reset values: `mem_word_q`=0, `mem_word_rdvalid`=0, `mem_word_overrun`=0, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, state ST_IDLE. `mem_word_busy` follows its inputs (0 when `rd`/`wr` are low).
- Request presented in cycle C: `ram_req` is high from C+1.
- With a zero-wait backend (ack in the first cycle `req` is seen):
  - LO ack in C+1, HI ack in C+2.
  - In C+3: `mem_word_q` valid, `mem_word_rdvalid` high, `ram_req` low, busy low.
- Minimum word cycle is 3 clocks. Each backend wait cycle adds 1.
- `mem_word_q` never changes except on an rdvalid cycle. Writes leave it untouched.
- Reset asserted mid-transaction: `ram_req` drops asynchronously and the state returns to ST_IDLE. The partial word is abandoned, with no rdvalid pulse. After reset deassertion the next request starts cleanly at ST_LO.

## Test plan
- Write 0xAAAA5555 to word 0x040000 with a zero-wait backend -> backend sees (addr 0x080000, we=1, data 0x5555), then (0x080001, we=1, 0xAAAA); `ram_req` is high C+1..C+2; busy is low at C+3; no rdvalid.
- Read word 0x040001 with the backend returning 0x1234 then 0xBEEF, ack delayed by 2 cycles each -> addresses 0x080002, 0x080003; `mem_word_q`=0xBEEF1234 with a one-cycle rdvalid at C+7; busy is high C..C+6.
- Read followed by a write: the write has no effect on `mem_word_q`, which keeps 0xBEEF1234.
- `mem_word_rd` and `mem_word_wr` high together -> only the write is performed; `mem_word_overrun`=1.
- A second `mem_word_wr` pulse while in ST_HI -> it is dropped; the in-flight write completes; overrun is set and stays set until reset.
- Assert `reset` between the LO and HI acks of a read -> `ram_req`=0 immediately, no rdvalid, all outputs at reset values. A following write completes normally.
- Stray `ram_ack` in ST_IDLE -> no state change and no output change.
